// File: rtl/tipi_nib_master.sv
// tipi_nib_master
//   Pi-side initiator for the TIPI nibble bus. Runs one register transaction
//   at a time: nibble-counter reset, select nibble, then two data nibbles
//   (high first). Writes go to RD/RC, reads come from TC/TD.
//
// Build option: TIPI_NIB_SYNC_EN adds a 2-flop synchronizer on r_nib_i and
//   stretches TURN and R_LO by 2 cycles so the synchronized value is sampled.
//
// Ports
//   clk, r_reset          system clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_op, req_wdata     0=rd TD, 1=rd TC, 2=wr RD, 3=wr RC; write byte
//   rsp_valid, rsp_data   one-cycle completion pulse, read byte (00 on writes)
//   r_clk_o, r_nibrst_o   bus strobe and nibble-counter reset
//   r_nib_o, r_nib_oe     outgoing nibble and its drive enable
//   r_nib_i               bus value seen from the target
module tipi_nib_master #(
    parameter int         HALF      = 2,
    parameter logic [3:0] SEL_RD_TD = 4'h0,
    parameter logic [3:0] SEL_RD_TC = 4'h1,
    parameter logic [3:0] SEL_WR_RD = 4'h2,
    parameter logic [3:0] SEL_WR_RC = 4'h3
) (
    input  logic       clk,
    input  logic       r_reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       r_clk_o,
    output logic       r_nibrst_o,
    output logic [3:0] r_nib_o,
    output logic       r_nib_oe,
    input  logic [3:0] r_nib_i
);

`ifdef TIPI_NIB_SYNC_EN
    localparam int XTRA = 2;
`else
    localparam int XTRA = 0;
`endif
    localparam int CW = $clog2(HALF + XTRA + 1) + 1;

    typedef enum logic [3:0] {
        S_IDLE, S_RST_HI, S_SEL_LO, S_SEL_HI, S_DH_LO, S_DH_HI, S_DL_LO,
        S_DL_HI, S_FIN, S_TURN, S_R_HI, S_R_LO, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      op_q, op_d;
    logic [7:0]      wdata_q, wdata_d;
    logic [3:0]      rd_hi_q, rd_hi_d;
    logic            req_ready_q, req_ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [7:0]      rsp_data_q, rsp_data_d;
    logic            r_clk_q, r_clk_d;
    logic            nibrst_q, nibrst_d;
    logic [3:0]      nib_q, nib_d;
    logic            oe_q, oe_d;
    logic [3:0]      nib_smp;
    logic [3:0]      sel;
    logic            last;

`ifdef TIPI_NIB_SYNC_EN
    logic [3:0] nib_s1_q, nib_s2_q;
    always_ff @(posedge clk) begin
        if (r_reset) begin
            nib_s1_q <= 4'h0;
            nib_s2_q <= 4'h0;
        end else begin
            nib_s1_q <= r_nib_i;
            nib_s2_q <= nib_s1_q;
        end
    end
    assign nib_smp = nib_s2_q;
`else
    assign nib_smp = r_nib_i;
`endif

    function automatic logic [CW-1:0] phase_len(input state_t s);
        if (s == S_TURN || s == S_R_LO) return CW'(HALF + XTRA);
        return CW'(HALF);
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        wdata_d     = wdata_q;
        rd_hi_d     = rd_hi_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = 1'b0;
        last        = (cnt_q == '0);

        case (state_q)
            S_IDLE: if (req_valid) begin
                op_d    = req_op;
                wdata_d = req_wdata;
                state_d = S_RST_HI;
            end
            S_DONE: state_d = S_IDLE;
            default: if (last) begin
                case (state_q)
                    S_RST_HI: state_d = S_SEL_LO;
                    S_SEL_LO: state_d = S_SEL_HI;
                    S_SEL_HI: state_d = op_q[1] ? S_DH_LO : S_TURN;
                    S_DH_LO:  state_d = S_DH_HI;
                    S_DH_HI:  state_d = S_DL_LO;
                    S_DL_LO:  state_d = S_DL_HI;
                    S_DL_HI:  state_d = S_FIN;
                    S_TURN:   state_d = S_R_HI;
                    S_R_HI:   state_d = S_R_LO;
                    default:  state_d = S_DONE;
                endcase
            end
        endcase

        // Reload on every state change so each phase runs its full length.
        if (state_d != state_q)  cnt_d = phase_len(state_d) - CW'(1);
        else if (!last)          cnt_d = cnt_q - CW'(1);

        if (state_q == S_TURN && last) rd_hi_d = nib_smp;

        // Low nibble is sampled on the same edge that enters DONE.
        if (state_d == S_DONE && state_q != S_DONE) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = op_q[1] ? 8'h00 : {rd_hi_q, nib_smp};
        end

        case (op_d)
            2'd0:    sel = SEL_RD_TD;
            2'd1:    sel = SEL_RD_TC;
            2'd2:    sel = SEL_WR_RD;
            default: sel = SEL_WR_RC;
        endcase

        // Bus outputs are decoded from the next state so they are registered
        // and line up with the state they belong to.
        req_ready_d = (state_d == S_IDLE);
        r_clk_d     = 1'b0;
        nibrst_d    = 1'b0;
        oe_d        = 1'b0;
        nib_d       = 4'h0;
        case (state_d)
            S_RST_HI: begin nibrst_d = 1'b1; oe_d = 1'b1; end
            S_SEL_LO: begin oe_d = 1'b1; nib_d = sel; end
            S_SEL_HI: begin oe_d = 1'b1; nib_d = sel; r_clk_d = 1'b1; end
            S_DH_LO:  begin oe_d = 1'b1; nib_d = wdata_d[7:4]; end
            S_DH_HI:  begin oe_d = 1'b1; nib_d = wdata_d[7:4]; r_clk_d = 1'b1; end
            S_DL_LO:  begin oe_d = 1'b1; nib_d = wdata_d[3:0]; end
            S_DL_HI:  begin oe_d = 1'b1; nib_d = wdata_d[3:0]; r_clk_d = 1'b1; end
            S_FIN:    begin oe_d = 1'b1; nib_d = wdata_d[3:0]; end
            S_R_HI:   r_clk_d = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (r_reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_q        <= 2'd0;
            wdata_q     <= 8'h00;
            rd_hi_q     <= 4'h0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            r_clk_q     <= 1'b0;
            nibrst_q    <= 1'b0;
            nib_q       <= 4'h0;
            oe_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            wdata_q     <= wdata_d;
            rd_hi_q     <= rd_hi_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            r_clk_q     <= r_clk_d;
            nibrst_q    <= nibrst_d;
            nib_q       <= nib_d;
            oe_q        <= oe_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign r_clk_o    = r_clk_q;
    assign r_nibrst_o = nibrst_q;
    assign r_nib_o    = nib_q;
    assign r_nib_oe   = oe_q;

endmodule

// File: tb/tb_tipi_nib_master.sv
module tb_tipi_nib_master;
    localparam int HALF   = 2;
    localparam int WR_LAT = 1 + 8 * HALF;
`ifdef TIPI_NIB_SYNC_EN
    localparam int RD_LAT = 1 + 6 * HALF + 4;
`else
    localparam int RD_LAT = 1 + 6 * HALF;
`endif

    logic       clk = 1'b0;
    logic       r_reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_op = 2'd0;
    logic [7:0] req_wdata = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       r_clk_o, r_nibrst_o, r_nib_oe;
    logic [3:0] r_nib_o;
    logic [3:0] r_nib_i = 4'h0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tipi_nib_master #(.HALF(HALF)) dut (
        .clk(clk), .r_reset(r_reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .r_clk_o(r_clk_o), .r_nibrst_o(r_nibrst_o),
        .r_nib_o(r_nib_o), .r_nib_oe(r_nib_oe), .r_nib_i(r_nib_i)
    );

    // Target-side model of tipi_top's nibble port: counts strobes after
    // nibrst, latches select/data on rising r_clk_o, serves TC/TD on reads.
    logic [7:0] bfm_tc = 8'h00, bfm_td = 8'h00;
    logic [7:0] bfm_rd = 8'h00, bfm_rc = 8'h00;
    logic [3:0] bfm_sel = 4'h0, bfm_hi = 4'h0;
    logic [3:0] bfm_seen [3];
    int         bfm_cnt = 0, bfm_oe_rises = 0, bfm_rises = 0;
    logic       prev_rclk = 1'b0;
    logic [3:0] prev_nib = 4'h0;
    int         viol = 0;

    always @(negedge clk) begin
        logic [7:0] src;
        if (r_clk_o && !prev_rclk && r_nib_o !== prev_nib) viol++;
        if (r_nibrst_o && r_clk_o) viol++;
        if (req_ready && !r_reset && (r_nib_oe || r_nib_o != 4'h0)) viol++;
        if (r_nibrst_o) begin
            bfm_cnt = 0; bfm_oe_rises = 0; bfm_rises = 0;
        end else if (r_clk_o && !prev_rclk) begin
            if (bfm_cnt < 3) bfm_seen[bfm_cnt] = r_nib_o;
            if (bfm_cnt == 0) bfm_sel = r_nib_o;
            else if (bfm_cnt == 1) bfm_hi = r_nib_o;
            else if (bfm_cnt == 2 && r_nib_oe) begin
                if (bfm_sel == 4'h2) bfm_rd = {bfm_hi, r_nib_o};
                if (bfm_sel == 4'h3) bfm_rc = {bfm_hi, r_nib_o};
            end
            if (r_nib_oe) bfm_oe_rises++;
            bfm_rises++;
            bfm_cnt++;
        end
        src = (bfm_sel == 4'h0) ? bfm_td : bfm_tc;
        r_nib_i = (bfm_cnt == 1) ? src[7:4] : (bfm_cnt == 2) ? src[3:0] : 4'h0;
        prev_rclk = r_clk_o;
        prev_nib  = r_nib_o;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the DONE cycle.
    task automatic run_txn(input logic [1:0] op, input logic [7:0] wd,
                           output int waits, output int lat, output logic [7:0] data);
        req_op = op; req_wdata = wd; req_valid = 1'b1; waits = 0;
        while (!req_ready && waits < 100) begin @(negedge clk); waits++; end
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = 2'($urandom); req_wdata = 8'($urandom);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 200);
        data = rsp_data;
    endtask

    // Reference expectations come straight from the register semantics.
    task automatic do_check(input string tag, input logic [1:0] op, input logic [7:0] wd,
                            input int exp_waits);
        int w, l; logic [7:0] d; logic [7:0] exp_d; logic [3:0] exp_sel;
        exp_sel = {2'b00, op};
        exp_d = (op == 2'd0) ? bfm_td : (op == 2'd1) ? bfm_tc : 8'h00;
        run_txn(op, wd, w, l, d);
        if (exp_waits >= 0) chk($sformatf("%s_waits", tag), w, exp_waits);
        chk($sformatf("%s_lat", tag), l, op[1] ? WR_LAT : RD_LAT);
        chk($sformatf("%s_data", tag), d, exp_d);
        chk($sformatf("%s_sel", tag), bfm_seen[0], exp_sel);
        chk($sformatf("%s_rises", tag), bfm_rises, op[1] ? 3 : 2);
        chk($sformatf("%s_oe_rises", tag), bfm_oe_rises, op[1] ? 3 : 1);
        chk($sformatf("%s_ready_done", tag), req_ready, 1'b0);
        if (op == 2'd2) chk($sformatf("%s_rd", tag), bfm_rd, wd);
        if (op == 2'd3) chk($sformatf("%s_rc", tag), bfm_rc, wd);
    endtask

    initial begin
        int seen_rsp;
        int gap;
        logic [1:0] rop;
        logic [7:0] rwd;

        repeat (3) @(negedge clk);
        r_reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_rclk", r_clk_o, 1'b0);
        chk("rst_nibrst", r_nibrst_o, 1'b0);
        chk("rst_oe", r_nib_oe, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 8'h00);

        do_check("wr_rd_a5", 2'd2, 8'ha5, 0);
        @(negedge clk);
        do_check("wr_rc_6b", 2'd3, 8'h6b, 0);
        @(negedge clk);
        bfm_tc = 8'ha5;
        do_check("rd_tc_a5", 2'd1, 8'h00, 0);
        @(negedge clk);
        bfm_td = 8'h5a;
        do_check("rd_td_5a", 2'd0, 8'hff, 0);
        do_check("b2b_wr_3c", 2'd2, 8'h3c, 1);
        @(negedge clk);

        // Reset during DH_HI of a write (cycles 1+4*HALF .. 5*HALF).
        req_op = 2'd2; req_wdata = 8'h99; req_valid = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0;
        repeat (1 + 4 * HALF) @(negedge clk);
        chk("abort_in_dh_hi", {r_clk_o, r_nib_oe, r_nib_o}, {1'b1, 1'b1, 4'h9});
        r_reset = 1'b1;
        @(negedge clk);
        r_reset = 1'b0;
        chk("abort_bus", {r_nib_oe, r_clk_o, r_nibrst_o}, 3'b000);
        chk("abort_ready", req_ready, 1'b1);
        seen_rsp = 0;
        repeat (20) begin @(negedge clk); if (rsp_valid) seen_rsp++; end
        chk("abort_no_rsp", seen_rsp, 0);
        chk("abort_rd_kept", bfm_rd, 8'h3c);
        bfm_tc = 8'hc3;
        do_check("post_abort_rd_tc", 2'd1, 8'h00, 0);

        for (int i = 0; i < 16; i++) begin
            rop = 2'($urandom_range(0, 3));
            rwd = 8'($urandom);
            bfm_tc = 8'($urandom);
            bfm_td = 8'($urandom);
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge clk);
            do_check($sformatf("rnd%0d", i), rop, rwd, (gap > 0) ? 0 : 1);
        end

        repeat (5) @(negedge clk);
        chk("bus_protocol", viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
